hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl_pkg.sv | 9 +
 rtl/hazard_ctrl_if.sv | 36 +++
 rtl/hazard_ctrl.sv | 110 +++++++++++
 tb/tb_hazard_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller.
package hazard_ctrl_pkg;

    typedef enum logic {
        RESET_CONTINUE = 1'b0,
        RESET_RESET    = 1'b1
    } reset_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline <-> hazard controller signal bundle; slave is the controller, master the pipeline.
interface hazard_ctrl_if;
    import hazard_ctrl_pkg::*;

    logic        Iwait;
    logic        Dwait;
    logic        exe_is_waiting;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        ex_memread;
    logic [4:0]  ex_dst;
    logic        ex_branch_taken;
    logic [63:0] ex_target;
    logic        stall_IF;
    logic        stall_ID;
    reset_t      reset_IF_ID;
    reset_t      reset_ID_EX;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic [31:0] bubble_cnt;

    modport master (
        output Iwait, Dwait, exe_is_waiting, id_rs1, id_rs2, ex_memread, ex_dst,
               ex_branch_taken, ex_target,
        input  stall_IF, stall_ID, reset_IF_ID, reset_ID_EX, redirect_valid, redirect_pc,
               bubble_cnt
    );

    modport slave (
        input  Iwait, Dwait, exe_is_waiting, id_rs1, id_rs2, ex_memread, ex_dst,
               ex_branch_taken, ex_target,
        output stall_IF, stall_ID, reset_IF_ID, reset_ID_EX, redirect_valid, redirect_pc,
               bubble_cnt
    );

endinterface

// File: rtl/hazard_ctrl.sv
// Stall/flush/redirect control for a 5-stage pipeline, with a saturating bubble counter.
// A taken branch behind an outstanding fetch is parked in StPend until the fetch retires.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
(
    input logic          clk,
    input logic          reset,
    hazard_ctrl_if.slave hz
);

    localparam logic [63:0] ResetPc = 64'h8000_0000;

    typedef enum logic {StRun, StPend} state_t;

    state_t      state_q, state_d;
    logic        rv_q, rv_d;
    logic [63:0] pc_q, pc_d;
    logic [31:0] cnt_q, cnt_d;

    logic   freeze;
    logic   load_use;
    logic   stall_if, stall_id, redirect_valid;
    reset_t rst_if_id, rst_id_ex;

    assign freeze   = hz.Dwait | hz.exe_is_waiting;
    assign load_use = hz.ex_memread && (hz.ex_dst != 5'd0) &&
                      ((hz.ex_dst == hz.id_rs1) || (hz.ex_dst == hz.id_rs2));

    always_comb begin
        state_d        = state_q;
        rv_d           = rv_q;
        pc_d           = pc_q;
        cnt_d          = cnt_q;
        stall_if       = 1'b0;
        stall_id       = 1'b0;
        rst_if_id      = RESET_CONTINUE;
        rst_id_ex      = RESET_CONTINUE;
        redirect_valid = rv_q;

        if (reset) begin
            rst_if_id      = RESET_RESET;
            rst_id_ex      = RESET_RESET;
            redirect_valid = 1'b0;
        end else if (freeze) begin
            // Whole pipe holds; ID/EX keeps its own contents, so no flushes.
            stall_if = 1'b1;
            stall_id = 1'b1;
        end else begin
            rv_d = 1'b0;
            unique case (state_q)
                StPend: begin
                    rst_if_id = RESET_RESET;
                    if (hz.Iwait) begin
                        stall_if = 1'b1;
                    end else begin
                        redirect_valid = 1'b1;
                        state_d        = StRun;
                    end
                end
                StRun: begin
                    if (hz.ex_branch_taken) begin
                        rst_if_id = RESET_RESET;
                        rst_id_ex = RESET_RESET;
                        pc_d      = hz.ex_target;
                        if (hz.Iwait) begin
                            state_d = StPend;
                        end else begin
                            rv_d = 1'b1;
                        end
                    end else if (load_use) begin
                        stall_if  = 1'b1;
                        stall_id  = 1'b1;
                        rst_id_ex = RESET_RESET;
                    end else if (hz.Iwait) begin
                        stall_if  = 1'b1;
                        rst_if_id = RESET_RESET;
                    end
                end
                default: state_d = StRun;
            endcase
        end

        if ((rst_id_ex == RESET_RESET) && (cnt_q != 32'hFFFF_FFFF)) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StRun;
            rv_q    <= 1'b0;
            pc_q    <= ResetPc;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            rv_q    <= rv_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign hz.stall_IF       = stall_if;
    assign hz.stall_ID       = stall_id;
    assign hz.reset_IF_ID    = rst_if_id;
    assign hz.reset_ID_EX    = rst_id_ex;
    assign hz.redirect_valid = redirect_valid;
    assign hz.redirect_pc    = pc_q;
    assign hz.bubble_cnt     = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus randomized traffic vs a rule model.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    hazard_ctrl_if hz ();

    hazard_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall_if;
        logic        stall_id;
        reset_t      r_ifid;
        reset_t      r_idex;
        logic        rv;
        logic [63:0] pc;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb_q[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: pending redirect, redirect due next cycle, redirect target, bubble count.
    bit          m_pend;
    bit          m_due;
    logic [63:0] m_pc;
    logic [31:0] m_cnt;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, req, $time);
        end
    endfunction

    task automatic model_reset();
        m_pend = 1'b0;
        m_due  = 1'b0;
        m_pc   = 64'h8000_0000;
        m_cnt  = 32'd0;
    endtask

    // Predict the outputs for the inputs now applied, queue them, then advance the model.
    task automatic issue();
        exp_t e;
        bit   frz;
        bit   lu;
        bit   due_next;
        e.stall_if = 1'b0;
        e.stall_id = 1'b0;
        e.r_ifid   = RESET_CONTINUE;
        e.r_idex   = RESET_CONTINUE;
        e.rv       = m_due;
        e.pc       = m_pc;
        e.cnt      = m_cnt;
        due_next   = 1'b0;
        if (reset) begin
            model_reset();
            e.r_ifid = RESET_RESET;
            e.r_idex = RESET_RESET;
            e.rv     = 1'b0;
            e.pc     = 64'h8000_0000;
            e.cnt    = 32'd0;
        end else begin
            frz = hz.Dwait || hz.exe_is_waiting;
            lu  = hz.ex_memread && hz.ex_dst != 0 &&
                  (hz.ex_dst == hz.id_rs1 || hz.ex_dst == hz.id_rs2);
            if (frz) begin
                e.stall_if = 1'b1;
                e.stall_id = 1'b1;
            end else begin
                if (m_pend) begin
                    e.r_ifid = RESET_RESET;
                    if (hz.Iwait) e.stall_if = 1'b1;
                    else begin
                        e.rv   = 1'b1;
                        m_pend = 1'b0;
                    end
                end else if (hz.ex_branch_taken) begin
                    e.r_ifid = RESET_RESET;
                    e.r_idex = RESET_RESET;
                    m_pc     = hz.ex_target;
                    if (hz.Iwait) m_pend = 1'b1;
                    else          due_next = 1'b1;
                end else if (lu) begin
                    e.stall_if = 1'b1;
                    e.stall_id = 1'b1;
                    e.r_idex   = RESET_RESET;
                end else if (hz.Iwait) begin
                    e.stall_if = 1'b1;
                    e.r_ifid   = RESET_RESET;
                end
                m_due = due_next;
                if (e.r_idex == RESET_RESET && m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
            end
        end
        sb_q.push_back(e);
        -> sample_ev;
    endtask

    task automatic set_in(bit iw, bit dw, bit ew, logic [4:0] rs1, logic [4:0] rs2, bit mr,
                          logic [4:0] dst, bit br, logic [63:0] tgt);
        hz.Iwait           = iw;
        hz.Dwait           = dw;
        hz.exe_is_waiting  = ew;
        hz.id_rs1          = rs1;
        hz.id_rs2          = rs2;
        hz.ex_memread      = mr;
        hz.ex_dst          = dst;
        hz.ex_branch_taken = br;
        hz.ex_target       = tgt;
    endtask

    task automatic drive(bit iw, bit dw, bit ew, logic [4:0] rs1, logic [4:0] rs2, bit mr,
                         logic [4:0] dst, bit br, logic [63:0] tgt);
        @(negedge clk);
        set_in(iw, dw, ew, rs1, rs2, mr, dst, br, tgt);
        issue();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 64'h0);
    endtask

    // Monitor: every issued cycle presents one set of outputs, compared just after the inputs settle.
    initial begin
        exp_t e;
        forever begin
            @(sample_ev);
            #1;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL sb_underflow: got 0 entries, required >=1");
            end else begin
                e = sb_q.pop_front();
                chk("stall_IF",       64'(hz.stall_IF),       64'(e.stall_if));
                chk("stall_ID",       64'(hz.stall_ID),       64'(e.stall_id));
                chk("reset_IF_ID",    64'(hz.reset_IF_ID),    64'(e.r_ifid));
                chk("reset_ID_EX",    64'(hz.reset_ID_EX),    64'(e.r_idex));
                chk("redirect_valid", 64'(hz.redirect_valid), 64'(e.rv));
                chk("redirect_pc",    hz.redirect_pc,         e.pc);
                chk("bubble_cnt",     64'(hz.bubble_cnt),     64'(e.cnt));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        set_in(0, 0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 64'h0);
        // Reset held for two cycles, then released between edges.
        idle(2);
        @(negedge clk);
        reset = 1'b0;
        set_in(0, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 64'h0);
        issue();
        idle(1);

        // Load-use on rs2.
        drive(0, 0, 0, 5'd3, 5'd5, 1, 5'd5, 0, 64'h0);
        idle(2);
        // Load to x0 never stalls.
        drive(0, 0, 0, 5'd0, 5'd0, 1, 5'd0, 0, 64'h0);

        // Taken branch with fetch idle.
        drive(0, 0, 0, 5'd1, 5'd2, 0, 5'd0, 1, 64'h8000_0100);
        idle(2);

        // Taken branch with fetch outstanding for three further cycles.
        drive(1, 0, 0, 5'd1, 5'd2, 0, 5'd0, 1, 64'h8000_0200);
        for (int i = 0; i < 3; i++) drive(1, 0, 0, 5'd1, 5'd2, 0, 5'd0, 1, 64'h8000_0300);
        drive(0, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 64'h0);
        idle(2);

        // Freeze over a branch + load-use; branch wins once released.
        for (int i = 0; i < 4; i++) drive(0, 1, 0, 5'd7, 5'd9, 1, 5'd7, 1, 64'h8000_0400);
        drive(0, 0, 0, 5'd7, 5'd9, 1, 5'd7, 1, 64'h8000_0400);
        drive(0, 0, 1, 5'd1, 5'd2, 0, 5'd0, 0, 64'h0);
        idle(2);

        // Asynchronous reset while a redirect is pending.
        drive(1, 0, 0, 5'd1, 5'd2, 0, 5'd0, 1, 64'h8000_0500);
        drive(1, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 64'h0);
        #2;
        reset = 1'b1;
        issue();
        drive(1, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 64'h0);
        @(negedge clk);
        reset = 1'b0;
        set_in(0, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 64'h0);
        issue();
        idle(3);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 99) < 1);
            set_in($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 10,
                   $urandom_range(0, 99) < 5, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), $urandom_range(0, 99) < 40,
                   5'($urandom_range(0, 7)), $urandom_range(0, 99) < 20,
                   {$urandom, $urandom});
            issue();
        end
        @(negedge clk);
        reset = 1'b0;
        set_in(0, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 64'h0);
        issue();

        // Counter saturation: preload near the top, then three bubbles.
        @(negedge clk);
        force dut.cnt_q = 32'hFFFF_FFFE;
        m_cnt = 32'hFFFF_FFFE;
        set_in(0, 0, 0, 5'd1, 5'd2, 0, 5'd0, 0, 64'h0);
        issue();
        @(negedge clk);
        release dut.cnt_q;
        set_in(0, 0, 0, 5'd4, 5'd6, 1, 5'd4, 0, 64'h0);
        issue();
        drive(0, 0, 0, 5'd4, 5'd6, 1, 5'd6, 0, 64'h0);
        drive(0, 0, 0, 5'd1, 5'd2, 0, 5'd0, 1, 64'h8000_0600);
        idle(2);

        @(negedge clk);
        #3;
        chk("sb_drain", 64'(sb_q.size()), 64'd0);
        chk("final_bubble_cnt", 64'(hz.bubble_cnt), 64'hFFFF_FFFF);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
